// File: rtl/hazard_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_control_unit_pkg
// Purpose : Shared constants and types for the pipeline hazard control unit.
// Rev     : 1.0  initial release
// ============================================================================
package hazard_control_unit_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_forward_select.sv
`default_nettype none
// ============================================================================
// Module  : hazard_control_unit_forward_select
// Purpose : Single-operand EX forwarding comparator (MEM beats WB, x0 never).
// Rev     : 1.0  initial release
// ============================================================================
module hazard_control_unit_forward_select
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            fwd
);

  always_comb begin
    fwd = FWD_REG;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_control_unit
// Purpose : Pipeline hold/flush control, forwarding selects, multiply sequencer.
// Rev     : 1.0  initial release
// ============================================================================
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mul_start,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic                  hold_pc,
  output logic                  hold_ifid,
  output logic                  clear_ifid,
  output logic                  hold_idex,
  output logic                  clear_idex,
  output logic                  clear_exmem,
  output logic                  pc_sel_branch,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  mc_busy,
  output logic                  mc_done,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int              MCW      = $clog2(MUL_LATENCY);
  localparam logic [MCW-1:0]  CNT_LAST = MCW'(MUL_LATENCY - 1);

  mc_state_t      state, state_nx;
  logic [MCW-1:0] cnt, cnt_nx;
  logic           mc_stall;
  logic           mc_last;
  logic           load_use;
  logic [1:0]     fwd_a_raw;
  logic [1:0]     fwd_b_raw;

  hazard_control_unit_forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs        (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .fwd          (fwd_a_raw)
  );

  hazard_control_unit_forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs        (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_reg_write(mem_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .fwd          (fwd_b_raw)
  );

  // The first EX cycle of a multiply is spent in IDLE, so BUSY covers the rest.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mc_stall = 1'b0;
    mc_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ex_mul_start) begin
          mc_stall = 1'b1;
          state_nx = ST_BUSY;
          cnt_nx   = MCW'(1);
        end
      end
      ST_BUSY: begin
        if (cnt == CNT_LAST) begin
          mc_last  = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          mc_stall = 1'b1;
          cnt_nx   = cnt + MCW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    hold_pc       = 1'b0;
    hold_ifid     = 1'b0;
    clear_ifid    = 1'b0;
    hold_idex     = 1'b0;
    clear_idex    = 1'b0;
    clear_exmem   = 1'b0;
    pc_sel_branch = 1'b0;
    fwd_a         = FWD_REG;
    fwd_b         = FWD_REG;
    mc_busy       = 1'b0;
    mc_done       = 1'b0;
    if (clear) begin
      clear_ifid  = 1'b1;
      clear_idex  = 1'b1;
      clear_exmem = 1'b1;
    end else begin
      fwd_a   = fwd_a_raw;
      fwd_b   = fwd_b_raw;
      mc_busy = (state == ST_BUSY);
      mc_done = mc_last;
      if (mc_stall) begin
        hold_pc     = 1'b1;
        hold_ifid   = 1'b1;
        hold_idex   = 1'b1;
        clear_exmem = 1'b1;
      end else if (ex_branch_taken) begin
        clear_ifid    = 1'b1;
        clear_idex    = 1'b1;
        pc_sel_branch = 1'b1;
      end else if (load_use) begin
        hold_pc    = 1'b1;
        hold_ifid  = 1'b1;
        clear_idex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (hold_pc && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_control_unit
// Purpose : Directed and random checks of hazard_control_unit vs a reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_control_unit;

  localparam int AW   = 5;
  localparam int ML   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clear;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mul_start;
  logic          mem_reg_write, wb_reg_write;
  logic          hold_pc, hold_ifid, clear_ifid, hold_idex, clear_idex, clear_exmem;
  logic          pc_sel_branch, mc_busy, mc_done;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  // Reference state: remaining multiply cycles after the accepting one, and the stall tally.
  int mul_left = 0;
  int stalls   = 0;

  logic [8:0] e_ctrl;
  logic [1:0] e_fwd_a, e_fwd_b;

  hazard_control_unit #(.REG_ADDR_W(AW), .MUL_LATENCY(ML), .CNT_W(CW)) dut (
    .clk(clk), .clear(clear),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mul_start(ex_mul_start),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .hold_pc(hold_pc), .hold_ifid(hold_ifid), .clear_ifid(clear_ifid),
    .hold_idex(hold_idex), .clear_idex(clear_idex), .clear_exmem(clear_exmem),
    .pc_sel_branch(pc_sel_branch), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] src);
    if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // ctrl = {hold_pc, hold_ifid, clear_ifid, hold_idex, clear_idex, clear_exmem, pc_sel_branch, mc_busy, mc_done}
  task automatic ref_outputs();
    logic stall, lu;
    e_ctrl  = 9'b0;
    e_fwd_a = 2'b00;
    e_fwd_b = 2'b00;
    if (clear) begin
      e_ctrl = 9'b001011000;
    end else begin
      stall = (mul_left == 0 && ex_mul_start) || (mul_left > 1);
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (stall)                e_ctrl = 9'b110101000;
      else if (ex_branch_taken) e_ctrl = 9'b001010100;
      else if (lu)              e_ctrl = 9'b110010000;
      e_ctrl[1] = (mul_left > 0);
      e_ctrl[0] = (mul_left == 1);
      e_fwd_a = ref_fwd(ex_rs1);
      e_fwd_b = ref_fwd(ex_rs2);
    end
  endtask

  task automatic ref_advance();
    if (clear) begin
      mul_left = 0;
      stalls   = 0;
    end else begin
      if (e_ctrl[8] && stalls < CMAX) stalls++;
      if (mul_left > 0) mul_left--;
      else if (ex_mul_start) mul_left = ML - 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are applied just after a rising edge; outputs checked mid-cycle.
  task automatic cycle(input string tag);
    #1;
    ref_outputs();
    chk({tag, ":ctrl"}, 32'({hold_pc, hold_ifid, clear_ifid, hold_idex, clear_idex,
                             clear_exmem, pc_sel_branch, mc_busy, mc_done}), 32'(e_ctrl));
    chk({tag, ":fwd_a"}, 32'(fwd_a), 32'(e_fwd_a));
    chk({tag, ":fwd_b"}, 32'(fwd_b), 32'(e_fwd_b));
    chk({tag, ":stall_count"}, 32'(stall_count), 32'(stalls));
    @(posedge clk);
    ref_advance();
    #1;
  endtask

  task automatic idle_inputs();
    clear = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_mul_start = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
  endtask

  initial begin
    idle_inputs();
    clear = 1'b1;
    cycle("reset0");
    cycle("reset1");
    clear = 1'b0;
    cycle("idle");
    chk("reset_count", 32'(stall_count), 32'd0);

    // Load-use on rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    cycle("load_use");
    chk("load_use_count", 32'(stall_count), 32'd1);

    // Branch squashes the load-use stall
    ex_branch_taken = 1'b1;
    cycle("branch_lu");
    chk("branch_lu_count", 32'(stall_count), 32'd1);

    // Two back-to-back multiplies, start held level
    idle_inputs();
    ex_mul_start = 1'b1;
    for (int i = 0; i < 2 * ML; i++) cycle($sformatf("mul%0d", i));
    ex_mul_start = 1'b0;
    cycle("mul_after");
    chk("mul_count", 32'(stall_count), 32'd7);

    // Forwarding priority and x0 exclusion
    ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    cycle("fwd_mem");
    chk("fwd_mem_a", 32'(fwd_a), 32'd2);
    mem_rd = 5'd0;
    cycle("fwd_wb");
    chk("fwd_wb_a", 32'(fwd_a), 32'd1);
    ex_rs1 = 5'd0;
    cycle("fwd_x0");
    chk("fwd_x0_a", 32'(fwd_a), 32'd0);

    // Reset in the middle of a multiply
    idle_inputs();
    ex_mul_start = 1'b1;
    cycle("rmul0");
    cycle("rmul1");
    clear = 1'b1;
    cycle("rmul_clear");
    clear = 1'b0; ex_mul_start = 1'b0;
    cycle("rmul_after");
    chk("rmul_busy", 32'(mc_busy), 32'd0);

    // Saturation of the stall counter
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    for (int i = 0; i < 20; i++) cycle("sat");
    chk("sat_count", 32'(stall_count), 32'(CMAX));

    // Random traffic over a small register range to provoke matches
    for (int i = 0; i < 400; i++) begin
      clear           = ($urandom_range(0, 24) == 0);
      id_rs1          = AW'($urandom_range(0, 3));
      id_rs2          = AW'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_rs1          = AW'($urandom_range(0, 3));
      ex_rs2          = AW'($urandom_range(0, 3));
      ex_rd           = AW'($urandom_range(0, 3));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      ex_mul_start    = ($urandom_range(0, 3) == 0);
      mem_rd          = AW'($urandom_range(0, 3));
      mem_reg_write   = 1'($urandom_range(0, 1));
      wb_rd           = AW'($urandom_range(0, 3));
      wb_reg_write    = 1'($urandom_range(0, 1));
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
